// File: rtl/redmule_mx_encoder_pp.sv
// redmule_mx_encoder_pp
//   FP16 -> MXFP8 block encoder with ping-pong block buffers. Incoming FP16
//   beats (NUM_LANES elements each) are gathered into BLOCK_SIZE-element
//   blocks. Each block gets one E8M0 shared scale and is re-encoded to E4M3
//   or E5M2 (format chosen per block), one group of NUM_LANES per cycle.
//   While one slot is being encoded or drained, the other slot can ingest.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   fmt_i               0 = E4M3, 1 = E5M2, taken from the first beat of a block
//   fp16_valid_i/ready_o/data_i   input beats, lane l at [16l+15:16l]
//   mx_val_valid_o/ready_i/data_o packed FP8 block, element i at [8i+7:8i]
//   mx_fmt_o            format of the presented block
//   mx_exp_valid_o/ready_i/data_o E8M0 shared scale of the presented block
//   busy_o              high while any slot holds data
//
// Build option
//   REDMULE_MX_ENC_SUBNORM_EN: produce FP8 subnormals on underflow instead
//   of flushing to zero.

module redmule_mx_encoder_pp #(
    parameter int unsigned NUM_LANES  = 8,
    parameter int unsigned BLOCK_SIZE = 32,
    parameter int unsigned NUM_GROUPS = BLOCK_SIZE / NUM_LANES,
    parameter int unsigned DATA_W     = BLOCK_SIZE * 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   fmt_i,
    input  logic                   fp16_valid_i,
    output logic                   fp16_ready_o,
    input  logic [NUM_LANES*16-1:0] fp16_data_i,
    output logic                   mx_val_valid_o,
    input  logic                   mx_val_ready_i,
    output logic [DATA_W-1:0]      mx_val_data_o,
    output logic                   mx_fmt_o,
    output logic                   mx_exp_valid_o,
    input  logic                   mx_exp_ready_i,
    output logic [7:0]             mx_exp_data_o,
    output logic                   busy_o
);

    localparam int unsigned GW     = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int unsigned BEAT_W = NUM_LANES * 16;
    localparam int unsigned OGRP_W = NUM_LANES * 8;

    typedef enum logic [2:0] {
        SLOT_FREE,
        SLOT_FILLING,
        SLOT_FULL,
        SLOT_ENCODING,
        SLOT_PRESENT
    } slot_e;

    slot_e                    slot_st    [2];
    logic [BLOCK_SIZE*16-1:0] slot_raw   [2];
    logic                     slot_fmt   [2];
    logic [7:0]               slot_scale [2];

    logic          ing_ptr, enc_ptr;
    logic [GW-1:0] ing_g, enc_g;
    logic [4:0]    run_max;

    logic [DATA_W-1:0] out_data;
    logic              out_fmt;
    logic [7:0]        out_exp;
    logic              val_valid, exp_valid;

    logic              fp16_hs, first_beat, last_beat;
    logic [4:0]        beat_max, blk_max;
    logic              blk_fmt;
    logic [BEAT_W-1:0] enc_grp_raw;
    logic [OGRP_W-1:0] enc_grp_out;
    logic              val_done, exp_done;

    function automatic logic [7:0] calc_scale(input logic [4:0] me, input logic fmt);
        int s;
        if (me == 5'd0) return 8'd127;
        s = int'(me) - 15 - (fmt ? 15 : 7) + 127;
        if (s < 0)   return 8'd0;
        if (s > 255) return 8'd255;
        return 8'(s);
    endfunction

`ifdef REDMULE_MX_ENC_SUBNORM_EN
    // Denormalise {1,m16} by 1-e8 and round RNE to the FP8 subnormal grid.
    // A round-up to 2^M lands on the exponent LSB, i.e. the minimum normal.
    function automatic logic [6:0] enc_subnorm(input logic [9:0] m16, input int e8,
                                               input int mb);
        logic [21:0] wide;
        logic [10:0] f;
        logic        up;
        int          sh;
        if (1 - e8 > mb + 1) return 7'd0;
        sh   = (10 - mb) + (1 - e8);
        wide = {1'b1, m16, 11'd0} >> sh;
        up   = wide[10] & ((|wide[9:0]) | wide[11]);
        f    = wide[21:11] + 11'(up);
        return 7'(f);
    endfunction
`endif

    function automatic logic [7:0] enc_elem(input logic [15:0] h, input logic fmt,
                                            input logic [7:0] scale);
        logic       s;
        logic [4:0] e16;
        logic [9:0] m16;
        logic [2:0] keep;
        logic       rnd, stk;
        logic [3:0] mant;
        logic [7:0] sat;
        int         e8, emaxb;
        s     = h[15];
        e16   = h[14:10];
        m16   = h[9:0];
        emaxb = fmt ? 30 : 14;
        sat   = fmt ? {s, 7'b1111011} : {s, 7'b1110111};
        e8    = int'(e16) - 15 - (int'(scale) - 127) + (fmt ? 15 : 7);
        if (e16 == 5'd0) begin
            return {s, 7'd0};
        end else if (e16 == 5'd31) begin
            return fmt ? {s, 5'b11111, 1'b0, (m16 != 10'd0)}
                       : {s, 4'b1111, 2'b00, (m16 != 10'd0)};
        end else if (e8 <= 0) begin
`ifdef REDMULE_MX_ENC_SUBNORM_EN
            return {s, enc_subnorm(m16, e8, fmt ? 2 : 3)};
`else
            return {s, 7'd0};
`endif
        end else if (e8 > emaxb) begin
            return sat;
        end
        if (fmt) begin
            keep = {1'b0, m16[9:8]};
            rnd  = m16[7];
            stk  = |m16[6:0];
        end else begin
            keep = m16[9:7];
            rnd  = m16[6];
            stk  = |m16[5:0];
        end
        mant = {1'b0, keep} + 4'(rnd & (stk | keep[0]));
        if (mant == (fmt ? 4'd4 : 4'd8)) begin
            mant = 4'd0;
            e8   = e8 + 1;
        end
        if (e8 > emaxb) return sat;
        return fmt ? {s, e8[4:0], mant[1:0]} : {s, e8[3:0], mant[2:0]};
    endfunction

    assign fp16_ready_o = (slot_st[ing_ptr] == SLOT_FREE) || (slot_st[ing_ptr] == SLOT_FILLING);
    assign fp16_hs      = fp16_valid_i & fp16_ready_o;
    assign first_beat   = (ing_g == '0);
    assign last_beat    = (ing_g == GW'(NUM_GROUPS - 1));
    assign blk_fmt      = first_beat ? fmt_i : slot_fmt[ing_ptr];

    always_comb begin
        beat_max = '0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            if ((fp16_data_i[16*l+10 +: 5] != 5'd0) && (fp16_data_i[16*l+10 +: 5] != 5'd31) &&
                (fp16_data_i[16*l+10 +: 5] > beat_max))
                beat_max = fp16_data_i[16*l+10 +: 5];
        end
        blk_max = beat_max;
        if (!first_beat && (run_max > beat_max)) blk_max = run_max;
    end

    always_comb begin
        enc_grp_raw = '0;
        enc_grp_out = '0;
        for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
            if (enc_g == GW'(g)) enc_grp_raw = slot_raw[enc_ptr][g*BEAT_W +: BEAT_W];
        end
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            enc_grp_out[8*l +: 8] = enc_elem(enc_grp_raw[16*l +: 16], slot_fmt[enc_ptr],
                                             slot_scale[enc_ptr]);
        end
    end

    assign val_done = !val_valid || mx_val_ready_i;
    assign exp_done = !exp_valid || mx_exp_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < 2; i++) begin
                slot_st[i]    <= SLOT_FREE;
                slot_raw[i]   <= '0;
                slot_fmt[i]   <= 1'b0;
                slot_scale[i] <= '0;
            end
            ing_ptr   <= 1'b0;
            enc_ptr   <= 1'b0;
            ing_g     <= '0;
            enc_g     <= '0;
            run_max   <= '0;
            out_data  <= '0;
            out_fmt   <= 1'b0;
            out_exp   <= '0;
            val_valid <= 1'b0;
            exp_valid <= 1'b0;
        end else begin
            // Ingest side only touches FREE/FILLING slots and the encode side
            // only FULL/ENCODING/PRESENT, so both may act in one cycle even
            // when the pointers coincide.
            if (fp16_hs) begin
                for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
                    if (ing_g == GW'(g)) slot_raw[ing_ptr][g*BEAT_W +: BEAT_W] <= fp16_data_i;
                end
                run_max <= blk_max;
                if (first_beat) slot_fmt[ing_ptr] <= fmt_i;
                if (last_beat) begin
                    slot_scale[ing_ptr] <= calc_scale(blk_max, blk_fmt);
                    slot_st[ing_ptr]    <= SLOT_FULL;
                    ing_ptr             <= ~ing_ptr;
                    ing_g               <= '0;
                end else begin
                    slot_st[ing_ptr] <= SLOT_FILLING;
                    ing_g            <= ing_g + GW'(1);
                end
            end

            // Group 0 is converted in the first FULL cycle so that the block
            // is presented NUM_GROUPS cycles after it became FULL.
            case (slot_st[enc_ptr])
                SLOT_FULL, SLOT_ENCODING: begin
                    for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
                        if (enc_g == GW'(g)) out_data[g*OGRP_W +: OGRP_W] <= enc_grp_out;
                    end
                    if (enc_g == GW'(NUM_GROUPS - 1)) begin
                        slot_st[enc_ptr] <= SLOT_PRESENT;
                        enc_g            <= '0;
                        val_valid        <= 1'b1;
                        exp_valid        <= 1'b1;
                        out_exp          <= slot_scale[enc_ptr];
                        out_fmt          <= slot_fmt[enc_ptr];
                    end else begin
                        slot_st[enc_ptr] <= SLOT_ENCODING;
                        enc_g            <= enc_g + GW'(1);
                    end
                end
                SLOT_PRESENT: begin
                    if (mx_val_ready_i) val_valid <= 1'b0;
                    if (mx_exp_ready_i) exp_valid <= 1'b0;
                    if (val_done && exp_done) begin
                        slot_st[enc_ptr] <= SLOT_FREE;
                        enc_ptr          <= ~enc_ptr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mx_val_valid_o = val_valid;
    assign mx_val_data_o  = out_data;
    assign mx_fmt_o       = out_fmt;
    assign mx_exp_valid_o = exp_valid;
    assign mx_exp_data_o  = out_exp;
    assign busy_o         = (slot_st[0] != SLOT_FREE) || (slot_st[1] != SLOT_FREE);

endmodule

// File: tb/tb_redmule_mx_encoder_pp.sv
// Testbench for redmule_mx_encoder_pp: directed and random blocks driven
// into the encoder, expected blocks computed by a value-level model and
// queued, and a monitor compares every output handshake against the queue.

module tb_redmule_mx_encoder_pp;

    localparam int NL = 8;
    localparam int BS = 32;
    localparam int NG = BS / NL;
    localparam int DW = BS * 8;

    typedef logic [15:0] blk_t [BS];

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          fmt_i = 1'b0;
    logic          fp16_valid_i = 1'b0;
    logic          fp16_ready_o;
    logic [NL*16-1:0] fp16_data_i = '0;
    logic          mx_val_valid_o;
    logic          mx_val_ready_i = 1'b1;
    logic [DW-1:0] mx_val_data_o;
    logic          mx_fmt_o;
    logic          mx_exp_valid_o;
    logic          mx_exp_ready_i = 1'b1;
    logic [7:0]    mx_exp_data_o;
    logic          busy_o;

    int nvec = 0;
    int nerr = 0;
    int rdy_mode = 0;  // 0: always ready, 1: random, 2: val stalled / exp ready

    logic [DW-1:0] val_q[$];
    logic          fmt_q[$];
    logic [7:0]    exp_q[$];

    always #5 clk_i = ~clk_i;

    redmule_mx_encoder_pp #(
        .NUM_LANES (NL),
        .BLOCK_SIZE(BS)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .fmt_i         (fmt_i),
        .fp16_valid_i  (fp16_valid_i),
        .fp16_ready_o  (fp16_ready_o),
        .fp16_data_i   (fp16_data_i),
        .mx_val_valid_o(mx_val_valid_o),
        .mx_val_ready_i(mx_val_ready_i),
        .mx_val_data_o (mx_val_data_o),
        .mx_fmt_o      (mx_fmt_o),
        .mx_exp_valid_o(mx_exp_valid_o),
        .mx_exp_ready_i(mx_exp_ready_i),
        .mx_exp_data_o (mx_exp_data_o),
        .busy_o        (busy_o)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (real-valued) ----------------
    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else        for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    // Magnitude represented by a 7-bit FP8 code.
    function automatic real code_val(input int c, input logic fmt);
        int mb   = fmt ? 2 : 3;
        int bias = fmt ? 15 : 7;
        int e    = c >> mb;
        int f    = c & ((1 << mb) - 1);
        if (e == 0) return real'(f) * pow2(1 - bias - mb);
        return real'((1 << mb) + f) * pow2(e - bias - mb);
    endfunction

    function automatic int model_scale(input blk_t b, input logic fmt);
        int mx = 0;
        int s;
        for (int i = 0; i < BS; i++) begin
            int e = int'(b[i][14:10]);
            if (e != 0 && e != 31 && e > mx) mx = e;
        end
        if (mx == 0) return 127;
        s = mx - 15 - (fmt ? 15 : 7) + 127;
        return (s < 0) ? 0 : (s > 255) ? 255 : s;
    endfunction

    // Nearest representable FP8 magnitude (ties to even code), saturating
    // at max finite; underflow below min normal flushes unless subnormals
    // are enabled.
    function automatic logic [7:0] model_elem(input logic [15:0] h, input logic fmt,
                                              input int scale);
        logic s = h[15];
        int   e = int'(h[14:10]);
        int   m = int'(h[9:0]);
        int   mb = fmt ? 2 : 3;
        int   bias = fmt ? 15 : 7;
        int   maxc = fmt ? 'h7B : 'h77;
        int   lo, best;
        real  x, bd, d;
        if (e == 0) return {s, 7'd0};
        if (e == 31) begin
            if (fmt) return (m == 0) ? {s, 7'h7C} : {s, 7'h7D};
            return (m == 0) ? {s, 7'h78} : {s, 7'h79};
        end
        x = (1.0 + real'(m) / 1024.0) * pow2(e - 15 - (scale - 127));
`ifdef REDMULE_MX_ENC_SUBNORM_EN
        lo = 0;
`else
        if (x < pow2(1 - bias)) return {s, 7'd0};
        lo = 1 << mb;
`endif
        best = lo;
        bd   = (x > code_val(lo, fmt)) ? x - code_val(lo, fmt) : code_val(lo, fmt) - x;
        for (int c = lo + 1; c <= maxc; c++) begin
            d = (x > code_val(c, fmt)) ? x - code_val(c, fmt) : code_val(c, fmt) - x;
            if (d < bd || (d == bd && (c % 2) == 0)) begin
                best = c;
                bd   = d;
            end
        end
        return {s, 7'(best)};
    endfunction

    task automatic push_expected(input blk_t b, input logic fmt);
        logic [DW-1:0] d;
        int sc = model_scale(b, fmt);
        for (int i = 0; i < BS; i++) d[8*i +: 8] = model_elem(b[i], fmt, sc);
        val_q.push_back(d);
        fmt_q.push_back(fmt);
        exp_q.push_back(8'(sc));
    endtask

    // ---------------- drivers ----------------
    always @(posedge clk_i) begin
        #1;
        case (rdy_mode)
            1: begin
                mx_val_ready_i = ($urandom_range(0, 3) != 0);
                mx_exp_ready_i = ($urandom_range(0, 3) != 0);
            end
            2: begin
                mx_val_ready_i = 1'b0;
                mx_exp_ready_i = 1'b1;
            end
            default: begin
                mx_val_ready_i = 1'b1;
                mx_exp_ready_i = 1'b1;
            end
        endcase
    end

    // Called at a negedge; returns one negedge after the last beat's handshake.
    task automatic send_block(input blk_t b, input logic fmt, input int nbeats, input int gap_max);
        for (int g = 0; g < nbeats; g++) begin
            int w = 0;
            repeat ($urandom_range(0, gap_max)) @(negedge clk_i);
            fp16_valid_i = 1'b1;
            fmt_i        = (g == 0) ? fmt : ~fmt;
            for (int l = 0; l < NL; l++) fp16_data_i[16*l +: 16] = b[g*NL+l];
            while (!fp16_ready_o && w < 400) begin
                @(negedge clk_i);
                w++;
            end
            if (!fp16_ready_o) begin
                nvec++;
                nerr++;
                $display("FAIL ingest_timeout: ready still %0b after %0d cycles, required 1", fp16_ready_o, w);
                fp16_valid_i = 1'b0;
                return;
            end
            if (g == NG - 1 && nbeats == NG) push_expected(b, fmt);
            @(negedge clk_i);
            fp16_valid_i = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int w = 0;
        while ((val_q.size() != 0 || exp_q.size() != 0 || busy_o) && w < 2000) begin
            @(negedge clk_i);
            w++;
        end
        nvec++;
        if (val_q.size() != 0 || exp_q.size() != 0 || busy_o) begin
            nerr++;
            $display("FAIL drain_timeout: %0d blocks / %0d scales pending, busy %0b, required none",
                     val_q.size(), exp_q.size(), busy_o);
        end
    endtask

    function automatic blk_t fill(input logic [15:0] v);
        blk_t b;
        for (int i = 0; i < BS; i++) b[i] = v;
        return b;
    endfunction

    function automatic blk_t rand_blk();
        blk_t b;
        int base = $urandom_range(1, 30);
        for (int i = 0; i < BS; i++) begin
            int r = $urandom_range(0, 31);
            int e = (r == 0) ? 0 : (r == 1) ? 31 : base - int'($urandom_range(0, 18));
            if (r > 1 && e < 1) e = 1;
            b[i] = {1'($urandom), 5'(e), 10'($urandom)};
        end
        return b;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (mx_val_valid_o && mx_val_ready_i) begin
                if (val_q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL val_unexpected: got block %0h, required no block", mx_val_data_o);
                end else begin
                    check("val_data", mx_val_data_o, val_q.pop_front());
                    check("val_fmt", DW'(mx_fmt_o), DW'(fmt_q.pop_front()));
                end
            end
            if (mx_exp_valid_o && mx_exp_ready_i) begin
                if (exp_q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL exp_unexpected: got scale %0h, required no scale", mx_exp_data_o);
                end else begin
                    check("exp_data", DW'(mx_exp_data_o), DW'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        nerr++;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        blk_t b;
        int   lat;

        repeat (3) @(negedge clk_i);
        check("rst_val_valid", DW'(mx_val_valid_o), DW'(0));
        check("rst_exp_valid", DW'(mx_exp_valid_o), DW'(0));
        check("rst_ready", DW'(fp16_ready_o), DW'(1));
        check("rst_busy", DW'(busy_o), DW'(0));
        check("rst_val_data", mx_val_data_o, DW'(0));
        check("rst_exp_data", DW'(mx_exp_data_o), DW'(0));
        rst_i = 1'b0;
        @(negedge clk_i);

        // Latency from last accepted beat to valids with an idle encoder.
        send_block(fill(16'h3C00), 1'b0, NG, 0);
        lat = 1;
        while (!mx_val_valid_o && lat < 40) begin
            @(negedge clk_i);
            lat++;
        end
        check("latency", DW'(lat), DW'(NG + 1));
        check("exp_valid_with_val", DW'(mx_exp_valid_o), DW'(1));
        wait_idle();

        // Directed blocks under random output readiness.
        rdy_mode = 1;
        send_block(fill(16'h3C00), 1'b1, NG, 0);
        send_block(fill(16'h0000), 1'b0, NG, 0);
        b = fill(16'h3C00); b[3] = 16'h7C00; b[17] = 16'h7E00; b[20] = 16'hFC00;
        send_block(b, 1'b0, NG, 0);
        b = fill(16'h3C00); b[1] = 16'h3C40; b[2] = 16'h3CC0; b[3] = 16'h3C60; b[9] = 16'hBCC0;
        send_block(b, 1'b0, NG, 1);
        b = fill(16'h1234); b[5] = 16'h5BFF;
        send_block(b, 1'b0, NG, 0);
        b = fill(16'h3C00); b[7] = 16'h0400; b[8] = 16'h8400; b[30] = 16'h0600;
        send_block(b, 1'b0, NG, 0);
        send_block(b, 1'b1, NG, 0);

        for (int k = 0; k < 60; k++) send_block(rand_blk(), 1'($urandom), NG, (k % 3 == 0) ? 0 : 2);
        wait_idle();

        // Scale accepted immediately, block accepted three cycles later.
        rdy_mode = 2;
        send_block(rand_blk(), 1'b0, NG, 0);
        lat = 0;
        while (!mx_val_valid_o && lat < 40) begin
            @(negedge clk_i);
            lat++;
        end
        repeat (3) @(negedge clk_i);
        check("split_exp_dropped", DW'(mx_exp_valid_o), DW'(0));
        check("split_val_held", DW'(mx_val_valid_o), DW'(1));
        rdy_mode = 0;
        repeat (2) @(negedge clk_i);
        check("split_val_retired", DW'(mx_val_valid_o), DW'(0));
        check("split_no_dup_exp", DW'(mx_exp_valid_o), DW'(0));
        wait_idle();

        // Output stalled: two blocks buffered, third block held off.
        rdy_mode = 2;
        send_block(rand_blk(), 1'b1, NG, 0);
        send_block(rand_blk(), 1'b0, NG, 0);
        fork
            send_block(rand_blk(), 1'b1, NG, 0);
            begin
                repeat (50) @(negedge clk_i);
                check("bp_ready_low", DW'(fp16_ready_o), DW'(0));
                check("bp_val_valid", DW'(mx_val_valid_o), DW'(1));
                check("bp_exp_taken", DW'(mx_exp_valid_o), DW'(0));
                check("bp_busy", DW'(busy_o), DW'(1));
                rdy_mode = 1;
            end
        join
        wait_idle();

        // Reset in the middle of a block discards it.
        send_block(rand_blk(), 1'b1, 2, 0);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("midrst_val_valid", DW'(mx_val_valid_o), DW'(0));
        check("midrst_exp_valid", DW'(mx_exp_valid_o), DW'(0));
        check("midrst_ready", DW'(fp16_ready_o), DW'(1));
        check("midrst_busy", DW'(busy_o), DW'(0));
        rst_i = 1'b0;
        @(negedge clk_i);
        send_block(fill(16'h3C00), 1'b0, NG, 0);
        send_block(rand_blk(), 1'b1, NG, 0);
        wait_idle();

        check("final_busy", DW'(busy_o), DW'(0));
        check("final_val_q", DW'(val_q.size()), DW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
